mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 254 +++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store stage: passes EX results through, or runs one aligned big-endian bus access at a time.
// States: IDLE | accepting EX results ; BUSY | bus access outstanding. Optional bus timeout: MEM_TIMEOUT_EN.
module mem_access_unit #(
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [3:0]            mem_op_i,
    input  logic [31:0]           write_data_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  rd_write_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [31:0]           mem_wdata_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [31:0]           mem_rdata_i,
    output logic [31:0]           write_data_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic                  rd_write_o,
    output logic                  out_valid_o,
    output logic                  stall_o,
    output logic                  addr_err_o,
    output logic                  bus_err_o,
    output logic [ADDR_W-1:0]     bad_addr_o
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    state_t                state_q, state_d;
    logic [3:0]            op_q, op_d;
    logic [1:0]            off_q, off_d;
    logic [REG_ADDR_W-1:0] cap_rd_q, cap_rd_d;
    logic                  cap_rdw_q, cap_rdw_d;
    logic                  req_q, req_d, we_q, we_d;
    logic [3:0]            be_q, be_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           wb_q, wb_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic                  rdw_q, rdw_d, ov_q, ov_d, aerr_q, aerr_d;
    logic [ADDR_W-1:0]     bad_q, bad_d;

    logic        is_load, is_store, misaligned;
    logic [3:0]  be_new;
    logic [31:0] store_data;
    logic [7:0]  lane8;
    logic [15:0] lane16;
    logic [31:0] load_val;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             berr_q, berr_d;
`endif

    always_comb begin
        is_load    = (mem_op_i >= OP_LB) && (mem_op_i <= OP_LW);
        is_store   = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
        misaligned = 1'b0;
        be_new     = 4'b0000;
        store_data = mem_wdata_i;
        case (mem_op_i)
            OP_LB, OP_LBU, OP_SB: begin
                be_new     = 4'b1000 >> mem_addr_i[1:0];
                store_data = {4{mem_wdata_i[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                misaligned = mem_addr_i[0];
                be_new     = mem_addr_i[1] ? 4'b0011 : 4'b1100;
                store_data = {2{mem_wdata_i[15:0]}};
            end
            OP_LW, OP_SW: begin
                misaligned = |mem_addr_i[1:0];
                be_new     = 4'b1111;
            end
            default: ;
        endcase
    end

    // Big-endian lanes: byte offset 0 lives in bits [31:24].
    always_comb begin
        case (off_q)
            2'd0:    lane8 = mem_rdata_i[31:24];
            2'd1:    lane8 = mem_rdata_i[23:16];
            2'd2:    lane8 = mem_rdata_i[15:8];
            default: lane8 = mem_rdata_i[7:0];
        endcase
        lane16 = off_q[1] ? mem_rdata_i[15:0] : mem_rdata_i[31:16];
        case (op_q)
            OP_LB:   load_val = {{24{lane8[7]}}, lane8};
            OP_LBU:  load_val = {24'd0, lane8};
            OP_LH:   load_val = {{16{lane16[15]}}, lane16};
            OP_LHU:  load_val = {16'd0, lane16};
            default: load_val = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        off_d     = off_q;
        cap_rd_d  = cap_rd_q;
        cap_rdw_d = cap_rdw_q;
        req_d     = req_q;
        we_d      = we_q;
        be_d      = be_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wb_d      = wb_q;
        rd_d      = rd_q;
        bad_d     = bad_q;
        rdw_d     = 1'b0;
        ov_d      = 1'b0;
        aerr_d    = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d     = cnt_q;
        berr_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (!is_load && !is_store) begin
                        wb_d  = write_data_i;
                        rd_d  = rd_addr_i;
                        rdw_d = rd_write_i;
                        ov_d  = 1'b1;
                    end else if (misaligned) begin
                        ov_d   = 1'b1;
                        aerr_d = 1'b1;
                        bad_d  = mem_addr_i;
                    end else begin
                        state_d   = BUSY;
                        req_d     = 1'b1;
                        we_d      = is_store;
                        be_d      = be_new;
                        addr_d    = {mem_addr_i[ADDR_W-1:2], 2'b00};
                        wdata_d   = store_data;
                        op_d      = mem_op_i;
                        off_d     = mem_addr_i[1:0];
                        cap_rd_d  = rd_addr_i;
                        cap_rdw_d = rd_write_i;
`ifdef MEM_TIMEOUT_EN
                        cnt_d     = CNT_W'(1);
`endif
                    end
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    ov_d    = 1'b1;
                    if (!we_q) begin
                        wb_d  = load_val;
                        rd_d  = cap_rd_q;
                        rdw_d = cap_rdw_q;
                    end
`ifdef MEM_TIMEOUT_EN
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    ov_d    = 1'b1;
                    berr_d  = 1'b1;
                    bad_d   = {addr_q[ADDR_W-1:2], off_q};
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            off_q     <= '0;
            cap_rd_q  <= '0;
            cap_rdw_q <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wb_q      <= '0;
            rd_q      <= '0;
            rdw_q     <= 1'b0;
            ov_q      <= 1'b0;
            aerr_q    <= 1'b0;
            bad_q     <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q     <= '0;
            berr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            off_q     <= off_d;
            cap_rd_q  <= cap_rd_d;
            cap_rdw_q <= cap_rdw_d;
            req_q     <= req_d;
            we_q      <= we_d;
            be_q      <= be_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wb_q      <= wb_d;
            rd_q      <= rd_d;
            rdw_q     <= rdw_d;
            ov_q      <= ov_d;
            aerr_q    <= aerr_d;
            bad_q     <= bad_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q     <= cnt_d;
            berr_q    <= berr_d;
`endif
        end
    end

    assign mem_req_o    = req_q;
    assign mem_we_o     = we_q;
    assign mem_be_o     = be_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign write_data_o = wb_q;
    assign rd_addr_o    = rd_q;
    assign rd_write_o   = rdw_q;
    assign out_valid_o  = ov_q;
    assign stall_o      = (state_q == BUSY);
    assign addr_err_o   = aerr_q;
    assign bad_addr_o   = bad_q;
`ifdef MEM_TIMEOUT_EN
    assign bus_err_o    = berr_q;
`else
    assign bus_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, corner-case sequences and random
// transactions checked against a transaction-level model of the load/store rules.
module tb_mem_access_unit;
    localparam int AW = 32;
    localparam int RW = 5;
    localparam int TO = 4;

    localparam int K_NONE = 0;
    localparam int K_MIS  = 1;
    localparam int K_LD   = 2;
    localparam int K_ST   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i;
    logic [3:0]    mem_op_i;
    logic [31:0]   write_data_i;
    logic [RW-1:0] rd_addr_i;
    logic          rd_write_i;
    logic [AW-1:0] mem_addr_i;
    logic [31:0]   mem_wdata_i;
    logic          mem_req_o, mem_we_o;
    logic [3:0]    mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic          mem_ack_i;
    logic [31:0]   mem_rdata_i;
    logic [31:0]   write_data_o;
    logic [RW-1:0] rd_addr_o;
    logic          rd_write_o, out_valid_o, stall_o, addr_err_o, bus_err_o;
    logic [AW-1:0] bad_addr_o;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(AW), .REG_ADDR_W(RW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .mem_op_i(mem_op_i),
        .write_data_i(write_data_i), .rd_addr_i(rd_addr_i), .rd_write_i(rd_write_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .write_data_o(write_data_o), .rd_addr_o(rd_addr_o), .rd_write_o(rd_write_o),
        .out_valid_o(out_valid_o), .stall_o(stall_o), .addr_err_o(addr_err_o),
        .bus_err_o(bus_err_o), .bad_addr_o(bad_addr_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]    op;
        logic [31:0]   addr, wdata, wdi, rdata;
        logic [RW-1:0] rd;
        logic          rdw;
        int            waits;
        int            kind;
        logic [3:0]    be;
        logic [31:0]   mwdata, result;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] wdi, input logic [31:0] rdata, input logic [RW-1:0] rd,
                                input logic rdw, input int waits, input int kind, input logic [3:0] be,
                                input logic [31:0] mwdata, input logic [31:0] result);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.wdi = wdi; v.rdata = rdata;
        v.rd = rd; v.rdw = rdw; v.waits = waits; v.kind = kind; v.be = be;
        v.mwdata = mwdata; v.result = result;
        return v;
    endfunction

    // Reference: access size from the opcode, lanes counted from the MSB end, arithmetic extension.
    function automatic vec_t model(input vec_t v);
        vec_t   r;
        int     size, off;
        longint val;
        r = v;
        r.be = 4'b0000; r.mwdata = 32'd0; r.result = 32'd0;
        off = int'(v.addr[1:0]);
        case (int'(v.op))
            1, 2, 6: size = 1;
            3, 4, 7: size = 2;
            5, 8:    size = 4;
            default: size = 0;
        endcase
        if (size == 0) r.kind = K_NONE;
        else if (off % size != 0) r.kind = K_MIS;
        else begin
            r.be = 4'(((1 << size) - 1) << (4 - off - size));
            if (int'(v.op) >= 6) begin
                r.kind = K_ST;
                if (size == 1)      r.mwdata = (v.wdata & 32'hFF) * 32'h01010101;
                else if (size == 2) r.mwdata = (v.wdata & 32'hFFFF) * 32'h00010001;
                else                r.mwdata = v.wdata;
            end else begin
                r.kind = K_LD;
                val = (longint'(v.rdata) >> (8 * (4 - off - size))) & ((longint'(1) << (8 * size)) - 1);
                if ((int'(v.op) == 1 || int'(v.op) == 3) && val >= (longint'(1) << (8 * size - 1)))
                    val = val - (longint'(1) << (8 * size));
                r.result = 32'(val);
            end
        end
        return r;
    endfunction

    task automatic start(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        valid_i = 1'b1; mem_op_i = op; mem_addr_i = addr; mem_wdata_i = wdata;
        rd_addr_i = 5'd9; rd_write_i = 1'b1; write_data_i = 32'h0;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        valid_i = 1'b1; mem_op_i = v.op; mem_addr_i = v.addr; mem_wdata_i = v.wdata;
        write_data_i = v.wdi; rd_addr_i = v.rd; rd_write_i = v.rdw;
        tick();
        valid_i = 1'b0; mem_op_i = 4'($urandom); mem_addr_i = $urandom; write_data_i = $urandom;
        case (v.kind)
            K_NONE: begin
                check("pass_valid", out_valid_o, 1);
                check("pass_data", write_data_o, v.wdi);
                check("pass_rd", rd_addr_o, v.rd);
                check("pass_rdw", rd_write_o, v.rdw);
                check("pass_stall", stall_o, 0);
                check("pass_req", mem_req_o, 0);
            end
            K_MIS: begin
                check("mis_valid", out_valid_o, 1);
                check("mis_err", addr_err_o, 1);
                check("mis_rdw", rd_write_o, 0);
                check("mis_bad", bad_addr_o, v.addr);
                check("mis_req", mem_req_o, 0);
            end
            default: begin
                check("bus_req", mem_req_o, 1);
                check("bus_stall", stall_o, 1);
                check("bus_we", mem_we_o, v.kind == K_ST);
                check("bus_be", mem_be_o, v.be);
                check("bus_addr", mem_addr_o, v.addr & ~32'h3);
                if (v.kind == K_ST) check("bus_wdata", mem_wdata_o, v.mwdata);
                check("bus_noval", out_valid_o, 0);
                for (int i = 0; i < v.waits; i++) begin
                    mem_rdata_i = $urandom;
                    tick();
                    check("wait_req", mem_req_o, 1);
                    check("wait_be", mem_be_o, v.be);
                    check("wait_addr", mem_addr_o, v.addr & ~32'h3);
                    check("wait_noval", out_valid_o, 0);
                end
                mem_ack_i = 1'b1; mem_rdata_i = v.rdata;
                tick();
                mem_ack_i = 1'b0; mem_rdata_i = $urandom;
                check("done_valid", out_valid_o, 1);
                check("done_req", mem_req_o, 0);
                check("done_stall", stall_o, 0);
                check("done_buserr", bus_err_o, 0);
                check("done_rdw", rd_write_o, (v.kind == K_ST) ? 1'b0 : v.rdw);
                if (v.kind == K_LD) begin
                    check("load_data", write_data_o, v.result);
                    check("load_rd", rd_addr_o, v.rd);
                end
            end
        endcase
        tick();
        check("pulse_valid", out_valid_o, 0);
        check("pulse_rdw", rd_write_o, 0);
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; valid_i = 1'b0; mem_op_i = 4'd0; write_data_i = 32'd0; rd_addr_i = '0;
        rd_write_i = 1'b0; mem_addr_i = '0; mem_wdata_i = 32'd0; mem_ack_i = 1'b0; mem_rdata_i = 32'd0;

        //        op     addr          wdata         wdi           rdata         rd     rdw w  kind    be       mwdata        result
        tbl.push_back(mk(4'd0, 32'h0,       32'h0,        32'h12345678, 32'h0,        5'd3,  1, 0, K_NONE, 4'b0000, 32'h0,        32'h0));
        tbl.push_back(mk(4'd1, 32'h101,     32'h0,        32'h0,        32'h11F23344, 5'd7,  1, 2, K_LD,   4'b0100, 32'h0,        32'hFFFFFFF2));
        tbl.push_back(mk(4'd2, 32'h101,     32'h0,        32'h0,        32'h11F23344, 5'd7,  1, 2, K_LD,   4'b0100, 32'h0,        32'h000000F2));
        tbl.push_back(mk(4'd7, 32'h202,     32'h0000ABCD, 32'h0,        32'h0,        5'd4,  1, 1, K_ST,   4'b0011, 32'hABCDABCD, 32'h0));
        tbl.push_back(mk(4'd5, 32'h103,     32'h0,        32'h0,        32'h0,        5'd5,  1, 0, K_MIS,  4'b0000, 32'h0,        32'h0));
        tbl.push_back(mk(4'd3, 32'h200,     32'h0,        32'h0,        32'h80011234, 5'd6,  1, 0, K_LD,   4'b1100, 32'h0,        32'hFFFF8001));
        tbl.push_back(mk(4'd4, 32'h206,     32'h0,        32'h0,        32'h1234F00D, 5'd8,  1, 3, K_LD,   4'b0011, 32'h0,        32'h0000F00D));
        tbl.push_back(mk(4'd6, 32'h303,     32'h000000A5, 32'h0,        32'h0,        5'd1,  1, 0, K_ST,   4'b0001, 32'hA5A5A5A5, 32'h0));
        tbl.push_back(mk(4'd8, 32'h400,     32'hDEADBEEF, 32'h0,        32'h0,        5'd2,  1, 1, K_ST,   4'b1111, 32'hDEADBEEF, 32'h0));
        tbl.push_back(mk(4'd5, 32'h404,     32'h0,        32'h0,        32'hCAFEBABE, 5'd10, 0, 3, K_LD,   4'b1111, 32'h0,        32'hCAFEBABE));
        tbl.push_back(mk(4'd3, 32'h201,     32'h0,        32'h0,        32'h0,        5'd11, 1, 0, K_MIS,  4'b0000, 32'h0,        32'h0));
        tbl.push_back(mk(4'd12, 32'h0,      32'h0,        32'hA5A50001, 32'h0,        5'd31, 0, 0, K_NONE, 4'b0000, 32'h0,        32'h0));
        tbl.push_back(mk(4'd1, 32'h103,     32'h0,        32'h0,        32'h0000007F, 5'd12, 1, 0, K_LD,   4'b0001, 32'h0,        32'h0000007F));

        tick();
        tick();
        check("rst_req", mem_req_o, 0);
        check("rst_valid", out_valid_o, 0);
        check("rst_stall", stall_o, 0);
        check("rst_wdata_o", write_data_o, 0);
        check("rst_bad", bad_addr_o, 0);
        check("rst_be", mem_be_o, 0);
        rst = 1'b0;
        tick();

        foreach (tbl[i]) run_vec(tbl[i]);
        check("bad_addr_held", bad_addr_o, 32'h201);

        // ack while idle must be ignored
        mem_ack_i = 1'b1; mem_rdata_i = 32'h55AA55AA;
        tick();
        check("idle_ack_valid", out_valid_o, 0);
        check("idle_ack_stall", stall_o, 0);
        tick();
        mem_ack_i = 1'b0;
        check("idle_ack_req", mem_req_o, 0);

        // valid_i while busy must be ignored
        start(4'd5, 32'h500, 32'h0);
        valid_i = 1'b1; mem_op_i = 4'd0; write_data_i = 32'h11111111;
        tick();
        tick();
        check("busy_valid_stall", stall_o, 1);
        check("busy_valid_noval", out_valid_o, 0);
        valid_i = 1'b0;
        mem_ack_i = 1'b1; mem_rdata_i = 32'h01020304;
        tick();
        mem_ack_i = 1'b0;
        check("busy_valid_data", write_data_o, 32'h01020304);
        tick();
        check("busy_valid_once", out_valid_o, 0);

        // reset abandons an access; a late ack is ignored
        start(4'd4, 32'h600, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstbusy_req", mem_req_o, 0);
        check("rstbusy_stall", stall_o, 0);
        check("rstbusy_valid", out_valid_o, 0);
        check("rstbusy_bad", bad_addr_o, 0);
        check("rstbusy_wdata_o", write_data_o, 0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;
        tick();
        mem_ack_i = 1'b0;
        check("late_ack_valid", out_valid_o, 0);
        check("late_ack_req", mem_req_o, 0);

`ifdef MEM_TIMEOUT_EN
        start(4'd5, 32'h700, 32'h0);
        for (int i = 2; i <= TO; i++) begin
            tick();
            check("to_stall", stall_o, 1);
        end
        tick();
        check("to_buserr", bus_err_o, 1);
        check("to_valid", out_valid_o, 1);
        check("to_rdw", rd_write_o, 0);
        check("to_bad", bad_addr_o, 32'h700);
        check("to_req", mem_req_o, 0);
        tick();
        check("to_pulse", bus_err_o, 0);
        start(4'd5, 32'h704, 32'h0);
        repeat (TO - 1) tick();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h0BADF00D;
        tick();
        mem_ack_i = 1'b0;
        check("to_ackwin_err", bus_err_o, 0);
        check("to_ackwin_valid", out_valid_o, 1);
        check("to_ackwin_data", write_data_o, 32'h0BADF00D);
        tick();
`else
        start(4'd5, 32'h700, 32'h0);
        repeat (10) tick();
        check("nto_stall", stall_o, 1);
        check("nto_req", mem_req_o, 1);
        check("nto_buserr", bus_err_o, 0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h0BADF00D;
        tick();
        mem_ack_i = 1'b0;
        check("nto_valid", out_valid_o, 1);
        check("nto_data", write_data_o, 32'h0BADF00D);
        tick();
`endif

        for (int n = 0; n < 60; n++) begin
            v.op = 4'($urandom_range(0, 15));
            v.addr = $urandom; v.wdata = $urandom; v.wdi = $urandom; v.rdata = $urandom;
            v.rd = RW'($urandom); v.rdw = 1'($urandom); v.waits = $urandom_range(0, 3);
            v.kind = K_NONE; v.be = 4'b0; v.mwdata = 32'h0; v.result = 32'h0;
            run_vec(model(v));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1);
    end

endmodule
